voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice allocator. Note events are accepted one at a time; each
// accepted event walks every voice once (one voice per clock) to find a
// matching voice, the lowest free voice and the oldest sounding voice, and
// then applies the update in a single APPLY cycle. When a note-on finds no
// free voice, the oldest voice is stolen: its gate drops for GAP_CYCLES
// clocks so the envelope can retrigger, then rises again with the new note.
//
// Handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both high. ev_ready is high only while the allocator is IDLE;
// ev_valid seen while ev_ready is low is ignored, and ev_type/ev_note are
// captured at the transfer edge, so later changes on them have no effect.
//
// Ports
//   clk       system clock, single domain
//   rst       synchronous active-high reset
//   ev_valid  event request
//   ev_ready  allocator idle / able to accept an event
//   ev_type   00 note-off, 01 note-on, 10 all-off, 11 no-op
//   ev_note   note number of the event
//   gate      per-voice gate, bit i drives voice i (registered)
//   note      per-voice note, voice i at [i*NOTE_W +: NOTE_W] (registered)
//   stolen    high for the one APPLY cycle in which a voice is stolen
// ---------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 8,
  parameter int GAP_CYCLES = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic [1:0]                   ev_type,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic [NUM_VOICES-1:0]        gate,
  output logic [NUM_VOICES*NOTE_W-1:0] note,
  output logic                         stolen
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] EV_OFF    = 2'b00;
  localparam logic [1:0] EV_ON     = 2'b01;
  localparam logic [1:0] EV_ALLOFF = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Latched event
  logic [1:0]        lat_type;
  logic [NOTE_W-1:0] lat_note;

  // Scan bookkeeping
  logic [IDX_W-1:0]  scan_idx;
  logic              match_found;
  logic [IDX_W-1:0]  match_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              old_found;
  logic [IDX_W-1:0]  old_idx;
  logic [7:0]        old_age;

  logic [GCNT_W-1:0] gap_cnt;

  // Voice state
  logic [NUM_VOICES-1:0] gate_q;
  logic [NOTE_W-1:0]     note_q [NUM_VOICES];
  logic [7:0]            age_q  [NUM_VOICES];

  // Combinational helpers
  logic              accept;
  logic              scan_last;
  logic              gap_done;
  logic              steal;
  logic              cur_gate;
  logic [NOTE_W-1:0] cur_note;
  logic [7:0]        cur_age;
  logic [IDX_W-1:0]  target_idx;

  function automatic logic [7:0] age_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  assign ev_ready  = (state == IDLE);
  assign accept    = ev_valid && ev_ready;
  assign scan_last = (scan_idx == IDX_W'(NUM_VOICES - 1));
  assign gap_done  = (gap_cnt == GCNT_W'(GAP_CYCLES - 1));

  // A note-on with neither a match nor a free voice has to steal.
  assign steal  = (lat_type == EV_ON) && !match_found && !free_found;
  assign stolen = (state == APPLY) && steal;

  assign cur_gate = gate_q[scan_idx];
  assign cur_note = note_q[scan_idx];
  assign cur_age  = age_q[scan_idx];

  // Voice touched by a note-on: retrigger a match, else fill the lowest free
  // voice, else steal the oldest.
  assign target_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (scan_last) state_next = APPLY;
      APPLY:   state_next = steal ? GAP : IDLE;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Event latch and scan bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_type    <= 2'b11;
      lat_note    <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        lat_type    <= ev_type;
        lat_note    <= ev_note;
        scan_idx    <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        old_found   <= 1'b0;
        old_age     <= '0;
      end
    end else if (state == SCAN) begin
      if (cur_gate && (cur_note == lat_note) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!cur_gate && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
      // Strict greater-than keeps the lowest index on equal ages.
      if (cur_gate && (!old_found || (cur_age > old_age))) begin
        old_found <= 1'b1;
        old_idx   <= scan_idx;
        old_age   <= cur_age;
      end
      scan_idx <= scan_idx + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Voice state: only changes on the APPLY edge and the final GAP edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q  <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else if (state == APPLY) begin
      gap_cnt <= '0;
      case (lat_type)
        EV_ON: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == target_idx) begin
              age_q[i] <= '0;
              if (!match_found) begin
                note_q[i] <= lat_note;
                // Free voice opens immediately; a stolen voice closes for the gap.
                gate_q[i] <= free_found;
              end
            end else if (gate_q[i]) begin
              age_q[i] <= age_inc(age_q[i]);
            end
          end
        end
        EV_OFF: begin
          if (match_found) begin
            gate_q[match_idx] <= 1'b0;
            age_q[match_idx]  <= '0;
          end
        end
        EV_ALLOFF: begin
          gate_q <= '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            age_q[i] <= '0;
          end
        end
        default: begin
        end
      endcase
    end else if (state == GAP) begin
      if (gap_done) begin
        gate_q[old_idx] <= 1'b1;
        gap_cnt         <= '0;
      end else begin
        gap_cnt <= gap_cnt + GCNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign gate = gate_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
    assign note[g*NOTE_W +: NOTE_W] = note_q[g];
  end

endmodule
